// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } kp_state_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Row 4 is "* 0 #", so it does not follow the 3*r+c+1 pattern of the digit rows.
  function automatic logic [3:0] key_code_of(input logic [1:4] row, input logic [1:3] col);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] code;
    r = row[1] ? 4'd0 : row[2] ? 4'd1 : row[3] ? 4'd2 : 4'd3;
    c = col[1] ? 4'd0 : col[2] ? 4'd1 : 4'd2;
    if (r == 4'd3) begin
      if (c == 4'd0)      code = KEY_STAR;
      else if (c == 4'd1) code = 4'd0;
      else                code = KEY_HASH;
    end else begin
      code = r * 4'd3 + c + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Saturating match counter shared by the press and release debounce phases.
module keypad_debounce_cnt #(
  parameter int W    = 3,
  parameter int TERM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TERM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row rotation, single-key debounce, one-hot h/v output
// with a guaranteed all-zero gap between successive keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL    = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:3] col_in,
  output logic [1:4] row_drv,
  output logic [1:3] h,
  output logic [1:4] v,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output kp_state_e  state_dbg
);

  localparam int MAXP = (DWELL > DEBOUNCE) ? DWELL : DEBOUNCE;
  localparam int CW   = $clog2(MAXP) + 1;

  kp_state_e     state;
  logic [CW-1:0] dwell_cnt;
  logic [1:4]    cand_row;
  logic [1:3]    cand_col;
  logic [1:4]    next_row;
  logic          db_tc;
  logic          db_clr;
  logic          db_en;
  logic          col_match;
  logic          col_zero;
  logic          col_single;
  logic          dwell_done;

  assign state_dbg  = state;
  assign next_row   = {row_drv[4], row_drv[1:3]};
  assign col_match  = (col_in == cand_col);
  assign col_zero   = (col_in == 3'b000);
  assign col_single = (col_in == 3'b100) || (col_in == 3'b010) || (col_in == 3'b001);
  assign dwell_done = (dwell_cnt == CW'(DWELL - 1));

  // Counter is held clear outside the two debounce phases, so each phase starts from 0.
  always_comb begin
    db_clr = 1'b1;
    db_en  = 1'b0;
    case (state)
      S_DEBOUNCE: begin
        db_en  = col_match;
        db_clr = !col_match || db_tc;
      end
      S_RELEASE: begin
        db_en  = col_zero;
        db_clr = col_match || (col_zero && db_tc);
      end
      default: ;
    endcase
  end

  keypad_debounce_cnt #(
    .W    (CW),
    .TERM (DEBOUNCE)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .clr   (db_clr),
    .en    (db_en),
    .tc    (db_tc)
  );

  // key_strobe is a one-cycle valid with no ready; h/v are levels held for the press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_SCAN;
      row_drv    <= 4'b1000;
      dwell_cnt  <= '0;
      cand_row   <= '0;
      cand_col   <= '0;
      h          <= '0;
      v          <= '0;
      key_code   <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      case (state)
        S_SCAN: begin
          if (!dwell_done) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end else begin
            dwell_cnt <= '0;
            if (col_single) begin
              cand_row <= row_drv;
              cand_col <= col_in;
              state    <= S_DEBOUNCE;
            end else begin
              row_drv <= next_row;
            end
          end
        end
        S_DEBOUNCE: begin
          if (!col_match) begin
            state   <= S_SCAN;
            row_drv <= next_row;
          end else if (db_tc) begin
            state      <= S_PRESSED;
            h          <= cand_col;
            v          <= cand_row;
            key_code   <= key_code_of(cand_row, cand_col);
            key_strobe <= 1'b1;
          end
        end
        S_PRESSED: begin
          if (!col_match) state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (col_match) begin
            state <= S_PRESSED;
          end else if (col_zero && db_tc) begin
            h       <= '0;
            v       <= '0;
            state   <= S_SCAN;
            row_drv <= next_row;
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model driver, event scoreboard and lock model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int DWELL_TB = 2;
  localparam int DEB_TB   = 4;
  localparam int W        = 28;
  localparam int DC       = 65535;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:3] col_in = 3'b000;
  logic [1:4] row_drv;
  logic [1:3] h;
  logic [1:4] v;
  logic [3:0] key_code;
  logic       key_strobe;
  kp_state_e  state_dbg;

  logic [15:0]  cyc = 16'd0;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           c0 = 0;
  logic [1:4]   key_row = 4'b0000;
  logic [1:3]   key_col = 3'b000;
  logic         ovr_en = 1'b0;
  logic [1:3]   ovr_val = 3'b000;
  logic [15:0]  lock_hist = 16'hFFFF;

  keypad_scanner #(.DWELL(DWELL_TB), .DEBOUNCE(DEB_TB)) dut (
    .clk        (clk),
    .reset      (reset),
    .col_in     (col_in),
    .row_drv    (row_drv),
    .h          (h),
    .v          (v),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .state_dbg  (state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // keypad model: a held key closes its column only while its row is driven
  initial begin
    forever begin
      @(posedge clk);
      #2;
      col_in = ovr_en ? ovr_val : ((row_drv == key_row) ? key_col : 3'b000);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input int cy, input logic pr, input logic [2:0] hh,
                                      input logic [3:0] vv, input logic [3:0] cd);
    return {16'(cy), pr, hh, vv, cd};
  endfunction

  function automatic logic [3:0] digit_of(input logic [1:3] hh, input logic [1:4] vv);
    case ({vv, hh})
      7'b1000_100: return 4'd1;
      7'b1000_010: return 4'd2;
      7'b1000_001: return 4'd3;
      7'b0100_100: return 4'd4;
      7'b0100_010: return 4'd5;
      7'b0100_001: return 4'd6;
      7'b0010_100: return 4'd7;
      7'b0010_010: return 4'd8;
      7'b0010_001: return 4'd9;
      7'b0001_100: return 4'd10;
      7'b0001_010: return 4'd0;
      7'b0001_001: return 4'd11;
      default:     return 4'd15;
    endcase
  endfunction

  // scoreboard monitor: pops on every strobe and on every h/v return to zero
  task automatic pop_compare(input logic kind);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0b h=%b v=%b code=%0d, required none (cycle %0d)",
               kind, h, v, key_code, cyc);
    end else begin
      e = exp_q.pop_front();
      check(kind ? "press_value" : "release_value", {20'd0, kind, h, v, key_code}, {20'd0, e[11:0]});
      if (e[27:12] != 16'hFFFF) check(kind ? "press_cycle" : "release_cycle", {16'd0, cyc}, {16'd0, e[27:12]});
    end
  endtask

  initial begin
    logic [6:0] hv;
    logic [6:0] prev_hv;
    logic       prev_stb;
    prev_hv  = '0;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_hv  = '0;
        prev_stb = 1'b0;
      end else begin
        hv = {h, v};
        if (key_strobe) begin
          check("strobe_width", {31'd0, prev_stb}, 32'd0);
          check("press_after_zero_gap", {25'd0, prev_hv}, 32'd0);
          pop_compare(1'b1);
          lock_hist = {lock_hist[11:0], digit_of(h, v)};
        end else if (hv != prev_hv) begin
          if (hv == 7'd0) pop_compare(1'b0);
          else check("hv_change_without_strobe", {25'd0, hv}, {25'd0, prev_hv});
        end
        prev_hv  = hv;
        prev_stb = key_strobe;
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    while (int'(cyc) < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input int bound, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending events after %0d cycles, required 0", name, exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_drv", {28'd0, row_drv}, 32'h8);
    check("rst_hv", {25'd0, h, v}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_strobe", {31'd0, key_strobe}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_SCAN});
    reset = 1'b1;
    c0 = int'(cyc);
  endtask

  task automatic press_key(input logic [3:0] row, input logic [2:0] col, input logic [3:0] code);
    key_row = row;
    key_col = col;
    exp_q.push_back(mk(DC, 1'b1, col, row, code));
    wait_empty(4 * DWELL_TB + DEB_TB + 10, "press");
    repeat (6) begin @(posedge clk); #1; end
    key_col = 3'b000;
    exp_q.push_back(mk(DC, 1'b0, 3'b000, 4'b0000, code));
    wait_empty(DEB_TB + 10, "release");
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // directed scenarios
  initial begin
    // idle scan: each row driven for DWELL cycles, nothing reported
    do_reset();
    for (int k = 0; k < 40; k++) begin
      wait_cyc(c0 + k);
      check("idle_row_drv", {28'd0, row_drv}, {28'd0, 4'b1000 >> ((k / 2) % 4)});
    end
    check("idle_hv", {25'd0, h, v}, 32'd0);

    // '5' held from reset: row 2 sampled on edge 4, h/v valid on edge 8
    key_row = 4'b0100;
    key_col = 3'b010;
    do_reset();
    exp_q.push_back(mk(c0 + 8, 1'b1, 3'b010, 4'b0100, 4'd5));
    wait_cyc(c0 + 20);
    check("hold5_hv", {25'd0, h, v}, {25'd0, 7'b010_0100});
    check("hold5_code", {28'd0, key_code}, 32'd5);
    wait_cyc(c0 + 28);
    key_col = 3'b000;
    exp_q.push_back(mk(c0 + 33, 1'b0, 3'b000, 4'b0000, 4'd5));
    wait_empty(20, "key5");

    // bounce on press: 010 sampled, 000 breaks debounce, scan moves on to row 3
    key_row = 4'b0100;
    key_col = 3'b010;
    do_reset();
    exp_q.push_back(mk(c0 + 17, 1'b1, 3'b010, 4'b0100, 4'd5));
    wait_cyc(c0 + 4);
    ovr_en  = 1'b1;
    ovr_val = 3'b000;
    wait_cyc(c0 + 5);
    check("bounce_row_adv", {28'd0, row_drv}, 32'h2);
    check("bounce_state", {30'd0, state_dbg}, {30'd0, S_SCAN});
    ovr_val = 3'b010;
    wait_cyc(c0 + 6);
    ovr_en = 1'b0;
    check("bounce_row_hold", {28'd0, row_drv}, 32'h2);
    wait_empty(30, "bounce_press");
    key_col = 3'b000;
    exp_q.push_back(mk(int'(cyc) + 5, 1'b0, 3'b000, 4'b0000, 4'd5));
    wait_empty(20, "bounce_release");

    // bounce on release of '0': 000,000,010 then clean zeros
    key_row = 4'b0001;
    key_col = 3'b010;
    do_reset();
    exp_q.push_back(mk(c0 + 12, 1'b1, 3'b010, 4'b0001, 4'd0));
    wait_cyc(c0 + 15);
    key_col = 3'b000;
    ovr_en  = 1'b1;
    ovr_val = 3'b000;
    wait_cyc(c0 + 17);
    ovr_val = 3'b010;
    wait_cyc(c0 + 18);
    ovr_en = 1'b0;
    exp_q.push_back(mk(c0 + 23, 1'b0, 3'b000, 4'b0000, 4'd0));
    wait_cyc(c0 + 22);
    check("relbounce_hold_hv", {25'd0, h, v}, {25'd0, 7'b010_0001});
    wait_empty(20, "relbounce");

    // ghost on row 1 is ignored, then the code 1,1,0,5 opens the lock
    key_row = 4'b0000;
    key_col = 3'b000;
    do_reset();
    key_row = 4'b1000;
    key_col = 3'b110;
    repeat (24) begin @(posedge clk); #1; end
    check("ghost_state", {30'd0, state_dbg}, {30'd0, S_SCAN});
    check("ghost_hv", {25'd0, h, v}, 32'd0);
    key_col = 3'b000;
    press_key(4'b1000, 3'b100, 4'd1);
    press_key(4'b1000, 3'b100, 4'd1);
    press_key(4'b0001, 3'b010, 4'd0);
    press_key(4'b0100, 3'b010, 4'd5);
    check("lock_open", {16'd0, lock_hist}, 32'h1105);

    // asynchronous reset while '#' is held
    key_row = 4'b0001;
    key_col = 3'b001;
    do_reset();
    exp_q.push_back(mk(c0 + 12, 1'b1, 3'b001, 4'b0001, KEY_HASH));
    wait_cyc(c0 + 14);
    check("hash_hv", {25'd0, h, v}, {25'd0, 7'b001_0001});
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_hv", {25'd0, h, v}, 32'd0);
    check("async_rst_code", {28'd0, key_code}, 32'd0);
    check("async_rst_row", {28'd0, row_drv}, 32'h8);
    key_col = 3'b000;
    do_reset();
    repeat (10) begin @(posedge clk); #1; end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
